// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
//   RESET_PC_DEFAULT : default program counter after reset
//   QDEPTH_DEFAULT   : default fetch queue depth
//   INST_W           : instruction / PC width
//   fetch_state_t    : sequencer states (IDLE / RUN / HOLD)
//   fetch_entry_t    : fetch queue entry {pc, inst}
//   align_pc()       : clears the byte-offset bits of a PC
package fetch_pkg;

  localparam int unsigned INST_W           = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned QDEPTH_DEFAULT   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Instructions are word aligned; the two low bits never reach the PC.
  function automatic logic [INST_W-1:0] align_pc(input logic [INST_W-1:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer holding fetched {pc, inst} entries for decode.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   flush             : empties the buffer (wins over push/pop)
//   push, push_data   : write one entry at the tail
//   pop               : drop the head entry (caller guarantees non-empty)
//   head              : entry at the read pointer
//   count             : number of valid entries
//   empty             : count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = QDEPTH_DEFAULT,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // The issue throttle reserves a slot for every in-flight word.
  a_no_push_when_full : assert property (@(posedge clk) disable iff (!reset)
    !(push && full && !flush));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one read per cycle to a
// 1-cycle-latency word-addressed memory, queues returned words and hands
// them to decode with valid/ready. A redirect flushes queued and in-flight
// words (via an epoch bit) and restarts at the new PC.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   fetch_en_i            : allows new memory requests
//   redirect_i            : one-cycle restart pulse
//   redirect_pc_i         : restart target (bits [1:0] ignored)
//   mem_req_o, mem_addr_o : read strobe and word index (combinational)
//   mem_rdata_i           : read data, valid the cycle after mem_req_o
//   inst_valid_o, inst_o, inst_pc_o : queue head presented to decode
//   inst_ready_i          : decode accepts the head this cycle
// Build option: FETCH_TRACE_EN prints issue and pop traces in simulation.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned QDEPTH   = QDEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [29:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        inst_ready_i
);

  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  fetch_state_t      state_q;
  logic [31:0]       pc_q;
  logic              epoch_q;
  logic              inflight_q;
  logic [31:0]       inflight_pc_q;
  logic              inflight_epoch_q;

  logic              pop;
  logic              push;
  logic              room;
  logic              issue;
  logic [OCC_W-1:0]  occ;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  fetch_entry_t      fifo_head;
  fetch_entry_t      push_entry;

  // Queued words plus the word in flight, after this cycle's pop.
  // A pop implies count >= 1, so the subtraction cannot underflow.
  assign pop   = inst_valid_o & inst_ready_i;
  assign occ   = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign room  = (occ < OCC_W'(QDEPTH));
  assign issue = (state_q != IDLE) & fetch_en_i & !redirect_i & room;

  assign mem_req_o  = issue;
  assign mem_addr_o = pc_q[31:2];

  // Responses from before the last redirect carry a stale epoch.
  assign push            = inflight_q & (inflight_epoch_q == epoch_q) & !redirect_i;
  assign push_entry.pc   = inflight_pc_q;
  assign push_entry.inst = mem_rdata_i;

  assign inst_valid_o = !fifo_empty;
  assign inst_o       = fifo_head.inst;
  assign inst_pc_o    = fifo_head.pc;

  // State, PC, epoch and in-flight tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      pc_q             <= RESET_PC;
      epoch_q          <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_epoch_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q    <= pc_q;
        inflight_epoch_q <= epoch_q;
      end

      if (redirect_i) begin
        epoch_q <= ~epoch_q;
        pc_q    <= align_pc(redirect_pc_i);
      end else if (issue) begin
        pc_q <= pc_q + 32'd4;
      end

      if (!fetch_en_i) begin
        state_q <= IDLE;
      end else if (redirect_i) begin
        state_q <= RUN;
      end else begin
        case (state_q)
          IDLE:      state_q <= RUN;
          RUN, HOLD: state_q <= room ? RUN : HOLD;
          default:   state_q <= IDLE;
        endcase
      end
    end
  end

  fetch_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_i),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

`ifdef FETCH_TRACE_EN
  // Simulation trace of every issued request and every word handed to decode.
  always @(posedge clk) begin
    if (reset && issue) begin
      $display("PC: %h, word %h", pc_q, pc_q >> 2);
    end
    if (reset && pop) begin
      $display("POP PC: %h, inst %h", inst_pc_o, inst_o);
    end
  end
`else
  // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a 1-cycle memory model and a scoreboard
// of expected fetch PCs; every word accepted by decode is checked in order.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en_i    (fetch_en_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_rdata_i   (mem_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .inst_ready_i  (inst_ready_i)
  );

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return {pc[31:2], 2'b11} ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_load(input logic [31:0] start, input int n);
    sb.delete();
    for (int i = 0; i < n; i++) sb.push_back(start + 32'(i * 4));
  endtask

  // Synchronous memory: data for a request appears the following cycle.
  always @(posedge clk)
    mem_rdata_i <= mem_req_o ? word_of({mem_addr_o, 2'b00}) : 32'hDEAD_BEEF;

  // Every handshake must deliver the next expected PC and its word.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (reset === 1'b1 && inst_valid_o && inst_ready_i) begin
      check("pop_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pop_pc", inst_pc_o, e);
        check("pop_inst", inst_o, word_of(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; fetch_en_i = 1'b0; redirect_i = 1'b0;
    redirect_pc_i = '0; inst_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req",   mem_req_o, 0);
    check("rst_addr",  mem_addr_o, 0);
    check("rst_valid", inst_valid_o, 0);
    check("rst_inst",  inst_o, 0);
    check("rst_pc",    inst_pc_o, 0);

    // Streaming from reset.
    @(posedge clk); #2;
    reset = 1'b1; fetch_en_i = 1'b1; inst_ready_i = 1'b1;
    sb_load(32'h0, 64);
    @(negedge clk); check("idle_before_edge", mem_req_o, 0);
    @(negedge clk); check("first_req", mem_req_o, 1); check("first_addr", mem_addr_o, 0);
    @(negedge clk); check("lat_valid_lo", inst_valid_o, 0); check("second_addr", mem_addr_o, 1);
    @(negedge clk); check("lat_valid_hi", inst_valid_o, 1); check("first_pc", inst_pc_o, 0);
    repeat (8) begin
      @(negedge clk); check("tput_valid", inst_valid_o, 1); check("tput_req", mem_req_o, 1);
    end

    // Decode stall: no requests, head stable at the next expected word.
    @(posedge clk); #1; inst_ready_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("stall_req", mem_req_o, 0);
      check("stall_valid", inst_valid_o, 1);
      check("stall_pc", inst_pc_o, sb[0]);
      check("stall_inst", inst_o, word_of(sb[0]));
    end
    @(posedge clk); #1; inst_ready_i = 1'b1;
    @(negedge clk); check("resume_req", mem_req_o, 1);
    repeat (5) @(negedge clk);

    // Redirect coinciding with a pop and an enqueue.
    @(posedge clk); #1; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    @(negedge clk); check("redir_no_req", mem_req_o, 0); check("redir_pop", inst_valid_o, 1);
    @(posedge clk); #1; redirect_i = 1'b0; sb_load(32'h100, 32);
    @(negedge clk);
    check("redir_empty_r1", inst_valid_o, 0);
    check("redir_req_r1", mem_req_o, 1);
    check("redir_addr_r1", mem_addr_o, 30'h40);
    @(negedge clk); check("redir_empty_r2", inst_valid_o, 0);
    @(negedge clk); check("redir_valid_r3", inst_valid_o, 1); check("redir_pc_r3", inst_pc_o, 32'h100);
    repeat (4) @(negedge clk);

    // Fill the queue, then redirect to the top of the address space.
    @(posedge clk); #1; inst_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1; redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
    @(negedge clk); check("full_redir_no_req", mem_req_o, 0);
    @(posedge clk); #1; redirect_i = 1'b0; inst_ready_i = 1'b1; sb_load(32'hFFFF_FFFC, 32);
    @(negedge clk); check("wrap_empty_r1", inst_valid_o, 0); check("wrap_addr_top", mem_addr_o, 30'h3FFF_FFFF);
    @(negedge clk); check("wrap_empty_r2", inst_valid_o, 0); check("wrap_addr_zero", mem_addr_o, 30'h0);
    @(negedge clk); check("wrap_pc_top", inst_pc_o, 32'hFFFF_FFFC);
    @(negedge clk); check("wrap_pc_zero", inst_pc_o, 32'h0);
    repeat (3) @(negedge clk);

    // Asynchronous reset between edges.
    @(posedge clk); #3; reset = 1'b0; #1;
    check("arst_req",   mem_req_o, 0);
    check("arst_addr",  mem_addr_o, 0);
    check("arst_valid", inst_valid_o, 0);
    check("arst_inst",  inst_o, 0);
    check("arst_pc",    inst_pc_o, 0);
    sb.delete();
    repeat (2) @(posedge clk); #2;
    reset = 1'b1; sb_load(32'h0, 32);
    @(negedge clk); check("restart_idle", mem_req_o, 0);
    @(negedge clk); check("restart_req", mem_req_o, 1); check("restart_addr", mem_addr_o, 0);
    @(negedge clk); check("restart_lat", inst_valid_o, 0);
    @(negedge clk); check("restart_valid", inst_valid_o, 1); check("restart_pc", inst_pc_o, 0);
    repeat (4) @(negedge clk);

    // Fetch disable: requests stop at once, in-flight data drains.
    @(posedge clk); #1; fetch_en_i = 1'b0;
    @(negedge clk); check("dis_req", mem_req_o, 0);
    repeat (2) @(negedge clk);
    check("dis_drained", inst_valid_o, 0); check("dis_req_late", mem_req_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer between the core front end and the word-addressed instruction memory. Owns the program counter, issues one read per cycle to a 1-cycle-latency synchronous memory, buffers returned words in a small queue, and presents them to decode with a valid/ready handshake. Handles redirects (branch/jump/trap) by discarding queued and in-flight words and restarting at the new PC.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `QDEPTH`, 2, fetch queue entries; power of two, ≥2.

- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `fetch_en_i` in 1: high allows new memory requests.
- `redirect_i` in 1: one-cycle pulse that restarts fetch.
- `redirect_pc_i` in 32: target PC; bits [1:0] are ignored and forced to 0.
- `mem_req_o` out 1: read strobe.
- `mem_addr_o` out 30: word index, `pc[31:2]`.
- `mem_rdata_i` in 32: read data, valid exactly the cycle after `mem_req_o`.
- `inst_valid_o` out 1: head of queue is valid.
- `inst_o` out 32: instruction word.
- `inst_pc_o` out 32: byte PC of `inst_o`.
- `inst_ready_i` in 1: decode accepts the head this cycle.

## Operation
- States:
  - IDLE: `fetch_en_i` is low; no requests.
  - RUN: issuing requests.
  - HOLD: the queue plus in-flight request fill `QDEPTH`.
- Transitions:
  - IDLE→RUN when `fetch_en_i` is high.
  - RUN→HOLD when an issue is blocked by lack of room.
  - HOLD→RUN when room frees.
  - Any state→IDLE when `fetch_en_i` is low. In-flight data still lands in the queue.
- Issue condition: state allows it, `!redirect_i`, and `count + inflight - pop < QDEPTH`, where `pop = inst_valid_o & inst_ready_i`. On issue, `pc <= pc + 4`. The 32-bit PC wraps from 0xFFFF_FFFC to 0 silently.
- Each request carries its PC and the current epoch bit. A response is enqueued only if its epoch matches the current epoch.
- Redirect:
  - Clear the queue (count = 0, pointers = 0).
  - Toggle the epoch, so an in-flight response is dropped.
  - Load `pc <= {redirect_pc_i[31:2], 2'b00}`.
  - No request is issued in the redirect cycle.
  - Redirect wins over a simultaneous pop, enqueue or issue.
- Pop and enqueue in the same cycle leave `count` unchanged.
- Enqueue into a full queue is impossible by construction. Cover this with an assertion.

## Timing
- Reset values:
  - `mem_req_o=0`, `mem_addr_o=RESET_PC[31:2]`, `inst_valid_o=0`, `inst_o=0`, `inst_pc_o=0`.
  - State IDLE, epoch 0, queue empty.
- Reset applied mid-operation clears everything immediately (asynchronous). The first request follows the first edge after release with `fetch_en_i` high.
- `mem_req_o` and `mem_addr_o` are combinational from state and registered PC.
- Request in cycle t → data is sampled at the end of t+1 → `inst_valid_o` is high in t+2. This gives 2-cycle latency.
- Sustained throughput is one instruction per cycle while `inst_ready_i` stays high (`QDEPTH=2` suffices).
- After a redirect in cycle r:
  - first request at r+1;
  - first valid instruction at r+3;
  - `inst_valid_o` is low in cycles r+1 and r+2.
- `inst_o` and `inst_pc_o` hold stable while `inst_valid_o && !inst_ready_i`.

## Configuration
- `FETCH_TRACE_EN` defined: on every issue, print `$display("PC: %h, word %h", pc, pc>>2)`; on every pop, print the PC and instruction.
- `FETCH_TRACE_EN` undefined: no display statements, identical RTL behaviour.

## Structure
- Shared package `fetch_pkg`:
  - `RESET_PC_DEFAULT`;
  - the state enum `fetch_state_t` (IDLE/RUN/HOLD);
  - `INST_W=32`;
  - the queue entry struct `{pc, inst}`.
- One sub-module, `fetch_fifo`: parameterised-depth circular buffer with push/pop/flush, `count`, and head outputs.
- Control, PC and epoch logic live in `fetch_ctrl`.

## Test plan
- Reset release, `fetch_en_i=1`, `inst_ready_i=1` → requests to words 0,1,2,…; `inst_valid_o` first high in cycle 2 with `inst_pc_o=0`; then one instruction per cycle at PCs 0,4,8,…
- `inst_ready_i=0` for 5 cycles → at most `QDEPTH` words buffered, `mem_req_o` low, head stable. On release, no word is skipped or duplicated.
- `redirect_i` with `redirect_pc_i=0x103` while the queue is full and a request is in flight:
  - nothing stale is delivered;
  - the next valid has `inst_pc_o=0x100`, 3 cycles later.
- Redirect in the same cycle as a pop and an enqueue → the queue is empty the next cycle and the epoch has toggled.
- PC at 0xFFFF_FFFC → the next request is word 0.
- Async `reset` low mid-stream, between clock edges → outputs take their reset values immediately; restart is at `RESET_PC`.
